// File: rtl/arm_ctrl_pkg.sv
// Shared control-path types for the multicycle ARM core: condition codes, NZCV
// bit positions, the long-multiply flag sequencer states and the flag-write helper.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_e;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   typedef enum logic {
      IDLE = 1'b0,
      LO   = 1'b1
   } l64_state_e;

   // Single-cycle flag update: FlagW[1] owns N,Z and FlagW[0] owns C,V, both
   // qualified by the registered condition pass.
   function automatic logic [3:0] apply_flag_write(
      input logic [3:0] flags,
      input logic [3:0] alu_flags,
      input logic [1:0] flag_w,
      input logic       cond_pass
   );
      logic [3:0] result;
      result = flags;
      if (flag_w[1] && cond_pass) begin
         result[N_BIT] = alu_flags[N_BIT];
         result[Z_BIT] = alu_flags[Z_BIT];
      end
      if (flag_w[0] && cond_pass) begin
         result[C_BIT] = alu_flags[C_BIT];
         result[V_BIT] = alu_flags[V_BIT];
      end
      return result;
   endfunction

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: Cond x NZCV -> pass/fail.
// NV (4'b1111) always fails.
module cond_check
   import arm_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v, ge;

   always_comb begin
      n  = flags[N_BIT];
      z  = flags[Z_BIT];
      c  = flags[C_BIT];
      v  = flags[V_BIT];
      ge = (n == v);
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cond_ex = 1'b0;
      case (cond_e'(cond))
         EQ: cond_ex = z;
         NE: cond_ex = ~z;
         CS: cond_ex = c;
         CC: cond_ex = ~c;
         MI: cond_ex = n;
         PL: cond_ex = ~n;
         VS: cond_ex = v;
         VC: cond_ex = ~v;
         HI: cond_ex = c & ~z;
         LS: cond_ex = ~c | z;
         GE: cond_ex = ge;
         LT: cond_ex = ~ge;
         GT: cond_ex = ~z & ge;
         LE: cond_ex = z | ~ge;
         AL: cond_ex = 1'b1;
         NV: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution and NZCV flag unit of the multicycle ARM core.
// Define COND_LONG64_EN to enable the two-cycle long-multiply flag sequencer.
module cond_logic
   import arm_ctrl_pkg::*;
#(
   parameter logic [3:0] FLAG_RST = 4'b0000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       Branch,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       Long64,
   input  logic       Long64Hi,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondExR
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;
   logic       cond_ex;

   cond_check u_cond_check (
      .cond    (Cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

`ifdef COND_LONG64_EN
   l64_state_e l64_q, l64_d;
   logic       zlo_q, zlo_d;
   logic       zlo_eff;

   // Long64Hi wins over Long64 and over a plain FlagW write; a high half seen
   // without a preceding low half behaves as if the low half were zero.
   always_comb begin
      flags_d   = flags_q;
      cond_ex_d = cond_ex;
      l64_d     = l64_q;
      zlo_d     = zlo_q;
      zlo_eff   = (l64_q == LO) ? zlo_q : 1'b1;
      if (Long64Hi) begin
         l64_d = IDLE;
         if (FlagW[1] && cond_ex_q) begin
            flags_d[N_BIT] = ALUFlags[N_BIT];
            flags_d[Z_BIT] = zlo_eff & ALUFlags[Z_BIT];
         end
      end else if (Long64) begin
         l64_d = LO;
         zlo_d = ALUFlags[Z_BIT];
      end else if (l64_q == IDLE) begin
         flags_d = apply_flag_write(flags_q, ALUFlags, FlagW, cond_ex_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l64_q <= IDLE;
         zlo_q <= 1'b0;
      end else begin
         l64_q <= l64_d;
         zlo_q <= zlo_d;
      end
   end
`else
   logic unused_long64;

   assign unused_long64 = Long64 ^ Long64Hi;

   always_comb begin
      flags_d   = apply_flag_write(flags_q, ALUFlags, FlagW, cond_ex_q);
      cond_ex_d = cond_ex;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q   <= FLAG_RST;
         cond_ex_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   assign PCWrite  = (Branch & cond_ex_q) | NextPC;
   assign RegWrite = RegW & cond_ex_q;
   assign MemWrite = MemW & cond_ex_q;
   assign Flags    = flags_q;
   assign CondExR  = cond_ex_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic; long-multiply cases follow COND_LONG64_EN.
module tb_cond_logic;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       Branch, NextPC, RegW, MemW, Long64, Long64Hi;
   logic       PCWrite, RegWrite, MemWrite, CondExR;
   logic [3:0] Flags;

   int total = 0;
   int bad   = 0;

   cond_logic #(.FLAG_RST(4'b0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .Branch   (Branch),
      .NextPC   (NextPC),
      .RegW     (RegW),
      .MemW     (MemW),
      .Long64   (Long64),
      .Long64Hi (Long64Hi),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .Flags    (Flags),
      .CondExR  (CondExR)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ALUFlags = 4'b0000;
      FlagW    = 2'b00;
      Branch   = 1'b0;
      NextPC   = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
      Long64   = 1'b0;
      Long64Hi = 1'b0;
   endtask

   // Load an arbitrary NZCV value through an always-passing instruction.
   task automatic set_flags(input logic [3:0] v);
      idle_inputs();
      Cond = 4'b1110;
      tick();
      FlagW    = 2'b11;
      ALUFlags = v;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      Cond = 4'b1110;
      RegW = 1'b1;
      #1;
      total++;
      if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b want=0", RegWrite); end
      total++;
      if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", Flags); end
      total++;
      if (CondExR !== 1'b0) begin bad++; $display("FAIL reset_condexr got=%b want=0", CondExR); end
      total++;
      if (PCWrite !== 1'b0 || MemWrite !== 1'b0) begin
         bad++; $display("FAIL reset_pc_mem got=%b%b want=00", PCWrite, MemWrite);
      end
      tick();
      total++;
      if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_held_regwrite got=%b want=0", RegWrite); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (RegWrite !== 1'b0) begin bad++; $display("FAIL release_regwrite got=%b want=0", RegWrite); end
      tick();
      total++;
      if (RegWrite !== 1'b1) begin bad++; $display("FAIL first_edge_regwrite got=%b want=1", RegWrite); end
      idle_inputs();
   endtask

   task automatic test_cond_table();
      logic [3:0]  fl [4];
      logic [15:0] ex [4];
      fl[0] = 4'b0100; ex[0] = 16'b0110_0110_1010_1001;
      fl[1] = 4'b1010; ex[1] = 16'b0110_1001_1001_0110;
      fl[2] = 4'b0011; ex[2] = 16'b0110_1001_0110_0110;
      fl[3] = 4'b1001; ex[3] = 16'b0101_0110_0101_1010;
      for (int f = 0; f < 4; f++) begin
         set_flags(fl[f]);
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c);
            tick();
            total++;
            if (CondExR !== ex[f][c]) begin
               bad++;
               $display("FAIL cond_table flags=%b cond=%0d got=%b want=%b", fl[f], c, CondExR, ex[f][c]);
            end
         end
      end
   endtask

   task automatic test_branch_gating();
      set_flags(4'b0100);
      total++;
      if (Flags !== 4'b0100) begin bad++; $display("FAIL setup_flags got=%b want=0100", Flags); end
      Cond = 4'b0000;
      tick();
      Branch = 1'b1;
      RegW   = 1'b1;
      MemW   = 1'b1;
      #1;
      total++;
      if (PCWrite !== 1'b1) begin bad++; $display("FAIL eq_branch got=%b want=1", PCWrite); end
      total++;
      if (RegWrite !== 1'b1 || MemWrite !== 1'b1) begin
         bad++; $display("FAIL eq_reg_mem got=%b%b want=11", RegWrite, MemWrite);
      end
      Cond   = 4'b0001;
      Branch = 1'b0;
      RegW   = 1'b0;
      MemW   = 1'b0;
      tick();
      Branch = 1'b1;
      RegW   = 1'b1;
      MemW   = 1'b1;
      #1;
      total++;
      if (PCWrite !== 1'b0) begin bad++; $display("FAIL ne_branch got=%b want=0", PCWrite); end
      total++;
      if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
         bad++; $display("FAIL ne_reg_mem got=%b%b want=00", RegWrite, MemWrite);
      end
      NextPC = 1'b1;
      #1;
      total++;
      if (PCWrite !== 1'b1) begin bad++; $display("FAIL ne_nextpc got=%b want=1", PCWrite); end
      idle_inputs();
   endtask

   task automatic test_flag_write();
      set_flags(4'b0000);
      FlagW    = 2'b10;
      ALUFlags = 4'b1011;
      tick();
      total++;
      if (Flags !== 4'b1000) begin bad++; $display("FAIL nz_write got=%b want=1000", Flags); end
      FlagW = 2'b01;
      tick();
      total++;
      if (Flags !== 4'b1011) begin bad++; $display("FAIL cv_write got=%b want=1011", Flags); end
      FlagW    = 2'b11;
      ALUFlags = 4'b0110;
      tick();
      total++;
      if (Flags !== 4'b0110) begin bad++; $display("FAIL both_write got=%b want=0110", Flags); end
   endtask

   task automatic test_nv();
      set_flags(4'b0101);
      Cond = 4'b1111;
      tick();
      MemW     = 1'b1;
      FlagW    = 2'b11;
      ALUFlags = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (MemWrite !== 1'b0) begin bad++; $display("FAIL nv_memwrite cyc=%0d got=%b want=0", i, MemWrite); end
         tick();
         total++;
         if (Flags !== 4'b0101) begin bad++; $display("FAIL nv_flags cyc=%0d got=%b want=0101", i, Flags); end
      end
      idle_inputs();
   endtask

`ifdef COND_LONG64_EN
   task automatic test_long64();
      set_flags(4'b0000);
      Long64   = 1'b1;
      FlagW    = 2'b10;
      ALUFlags = 4'b0100;
      tick();
      total++;
      if (Flags !== 4'b0000) begin bad++; $display("FAIL l64_lo_nowrite got=%b want=0000", Flags); end
      Long64   = 1'b0;
      Long64Hi = 1'b1;
      tick();
      total++;
      if (Flags !== 4'b0100) begin bad++; $display("FAIL l64_zlo1 got=%b want=0100", Flags); end
      Long64Hi = 1'b0;
      Long64   = 1'b1;
      ALUFlags = 4'b0000;
      tick();
      Long64   = 1'b0;
      Long64Hi = 1'b1;
      ALUFlags = 4'b0100;
      tick();
      total++;
      if (Flags !== 4'b0000) begin bad++; $display("FAIL l64_zlo0 got=%b want=0000", Flags); end
      Long64Hi = 1'b0;
      Long64   = 1'b1;
      ALUFlags = 4'b0000;
      tick();
      ALUFlags = 4'b0100;
      tick();
      Long64   = 1'b0;
      Long64Hi = 1'b1;
      FlagW    = 2'b11;
      ALUFlags = 4'b1111;
      tick();
      total++;
      if (Flags !== 4'b1100) begin bad++; $display("FAIL l64_restart_cv got=%b want=1100", Flags); end
      set_flags(4'b0000);
      Long64   = 1'b1;
      Long64Hi = 1'b1;
      FlagW    = 2'b10;
      ALUFlags = 4'b0100;
      tick();
      total++;
      if (Flags !== 4'b0100) begin bad++; $display("FAIL l64_both_high got=%b want=0100", Flags); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      set_flags(4'b1011);
      Long64   = 1'b1;
      ALUFlags = 4'b0000;
      tick();
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (Flags !== 4'b0000 || CondExR !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%b/%b want=0000/0", Flags, CondExR);
      end
      @(negedge clk);
      reset = 1'b0;
      Cond  = 4'b1110;
      tick();
      Long64Hi = 1'b1;
      FlagW    = 2'b10;
      ALUFlags = 4'b0100;
      tick();
      total++;
      if (Flags !== 4'b0100) begin bad++; $display("FAIL post_reset_zlo got=%b want=0100", Flags); end
      idle_inputs();
   endtask
`else
   task automatic test_long64();
      set_flags(4'b0000);
      Long64   = 1'b1;
      FlagW    = 2'b10;
      ALUFlags = 4'b1100;
      tick();
      total++;
      if (Flags !== 4'b1100) begin bad++; $display("FAIL l64_ignored_lo got=%b want=1100", Flags); end
      Long64   = 1'b0;
      Long64Hi = 1'b1;
      FlagW    = 2'b01;
      ALUFlags = 4'b0111;
      tick();
      total++;
      if (Flags !== 4'b1111) begin bad++; $display("FAIL l64_ignored_hi got=%b want=1111", Flags); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      set_flags(4'b1011);
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (Flags !== 4'b0000 || CondExR !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%b/%b want=0000/0", Flags, CondExR);
      end
      @(negedge clk);
      reset = 1'b0;
      Cond  = 4'b1110;
      tick();
      FlagW    = 2'b10;
      ALUFlags = 4'b0100;
      tick();
      total++;
      if (Flags !== 4'b0100) begin bad++; $display("FAIL post_reset_write got=%b want=0100", Flags); end
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_cond_table();
      test_branch_gating();
      test_flag_write();
      test_nv();
      test_long64();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
